// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) front end for the word RAM, with a per-access watchdog.
// Define MEM_ARB_RR_EN for round-robin grant under contention; default is data-first fixed priority.
module mem_arbiter #(
  parameter int TIMEOUT_CYC = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_ack,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] r_addr,
  output logic [31:0] w_addr,
  output logic [31:0] w_line,
  output logic        read,
  output logic        write,
  input  logic [31:0] r_line,
  input  logic        rrdy,
  input  logic        wrdy,
  input  logic        exc
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t state, state_nxt;

  logic [TO_W-1:0] wd_cnt, wd_cnt_nxt;
  logic            gnt_d, gnt_d_nxt;
  logic            grant_d, any_req;
  logic            rdy_hit, exc_hit, to_hit, done;
  logic            err_val;
  logic [31:0]     rdata_val;

  logic [31:0] r_addr_nxt, w_addr_nxt, w_line_nxt, if_data_nxt, d_rdata_nxt;
  logic        read_nxt, write_nxt, if_ack_nxt, if_err_nxt, d_ack_nxt, d_err_nxt;

  // gnt_d doubles as the "last granted" pointer; reset value 0 means fetch.
  always_comb begin
    any_req = if_req | d_req;
`ifdef MEM_ARB_RR_EN
    if (if_req && d_req) grant_d = ~gnt_d;
    else                 grant_d = d_req;
`else
    grant_d = d_req;
`endif
  end

  // exc seen on the first access cycle is left over from the previous access.
  always_comb begin
    rdy_hit = ((state == RD) && rrdy) || ((state == WR) && wrdy);
    exc_hit = exc && (wd_cnt != '0);
    to_hit  = (wd_cnt == TO_W'(TIMEOUT_CYC - 1));
    done    = (state != IDLE) && (rdy_hit || exc_hit || to_hit);
    err_val = ~rdy_hit;
    rdata_val = ((state == RD) && rrdy) ? r_line : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = (grant_d && d_we) ? WR : RD;
      RD, WR:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    r_addr_nxt  = r_addr;
    w_addr_nxt  = w_addr;
    w_line_nxt  = w_line;
    if_data_nxt = if_data;
    d_rdata_nxt = d_rdata;
    read_nxt    = 1'b0;
    write_nxt   = 1'b0;
    if_ack_nxt  = 1'b0;
    if_err_nxt  = 1'b0;
    d_ack_nxt   = 1'b0;
    d_err_nxt   = 1'b0;
    gnt_d_nxt   = gnt_d;
    wd_cnt_nxt  = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_d_nxt = grant_d;
          if (grant_d && d_we) begin
            write_nxt  = 1'b1;
            w_addr_nxt = d_addr;
            w_line_nxt = d_wdata;
          end else begin
            read_nxt   = 1'b1;
            r_addr_nxt = grant_d ? d_addr : if_addr;
          end
        end
      end
      RD, WR: begin
        if (done) begin
          if (gnt_d) begin
            d_ack_nxt   = 1'b1;
            d_err_nxt   = err_val;
            d_rdata_nxt = rdata_val;
          end else begin
            if_ack_nxt  = 1'b1;
            if_err_nxt  = err_val;
            if_data_nxt = rdata_val;
          end
        end else begin
          read_nxt   = (state == RD);
          write_nxt  = (state == WR);
          wd_cnt_nxt = wd_cnt + TO_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      w_addr  <= '0;
      w_line  <= '0;
      read    <= 1'b0;
      write   <= 1'b0;
      if_data <= '0;
      if_ack  <= 1'b0;
      if_err  <= 1'b0;
      d_rdata <= '0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      gnt_d   <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      r_addr  <= r_addr_nxt;
      w_addr  <= w_addr_nxt;
      w_line  <= w_line_nxt;
      read    <= read_nxt;
      write   <= write_nxt;
      if_data <= if_data_nxt;
      if_ack  <= if_ack_nxt;
      if_err  <= if_err_nxt;
      d_rdata <= d_rdata_nxt;
      d_ack   <= d_ack_nxt;
      d_err   <= d_err_nxt;
      gnt_d   <= gnt_d_nxt;
      wd_cnt  <= wd_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: word-RAM model plus a transaction-level reference
// (memory image, grant-order rule, fixed completion latencies).
module tb_mem_arbiter;

  localparam int TIMEOUT_CYC = 16;
  localparam int TO_W        = 5;
  localparam int MEM_WORDS   = 1024;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_data, d_rdata;
  logic        if_ack, if_err, d_ack, d_err;
  logic [31:0] r_addr, w_addr, w_line, r_line;
  logic        read, write, rrdy, wrdy, exc;

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;
  bit hang = 1'b0;
  bit ram_init_done = 1'b0;
  bit last_d = 1'b0;
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] mem [MEM_WORDS];

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .r_addr(r_addr), .w_addr(w_addr), .w_line(w_line), .read(read), .write(write),
    .r_line(r_line), .rrdy(rrdy), .wrdy(wrdy), .exc(exc)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A_0000;
  endfunction

  // One-cycle RAM: answers a strobe on the next edge, rdy self-clears, exc sticky until a good access.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrdy   <= 1'b0;
      wrdy   <= 1'b0;
      exc    <= 1'b0;
      r_line <= '0;
      if (!ram_init_done) begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
        ram_init_done <= 1'b1;
      end
    end else begin
      rrdy   <= 1'b0;
      wrdy   <= 1'b0;
      r_line <= $urandom;
      if (!hang && !rrdy && !wrdy && (read || write)) begin
        if ((read ? r_addr : w_addr) >= 32'(MEM_WORDS)) exc <= 1'b1;
        else begin
          exc <= 1'b0;
          if (read) begin
            rrdy   <= 1'b1;
            r_line <= mem[r_addr[9:0]];
          end else begin
            wrdy <= 1'b1;
            mem[w_addr[9:0]] <= w_line;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One uncontended access, checked for strobe, address, latency, status and data.
  task automatic applyStimulus(input bit is_d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input string tag);
    bit          exp_err, exp_rd, got;
    logic [31:0] exp_data, dat_obs, addr_obs, line_obs;
    logic        err_obs, other_obs, strobe_obs;
    int          cyc, exp_lat;
    exp_rd   = !(is_d && we);
    exp_err  = hang || (addr >= 32'(MEM_WORDS));
    exp_data = (exp_err || !exp_rd) ? 32'h0 : ref_mem[addr[9:0]];
    if (!exp_err && !exp_rd) ref_mem[addr[9:0]] = wdata;
    exp_lat  = hang ? TIMEOUT_CYC + 1 : 3;
    last_d   = is_d;

    @(negedge clk);
    if_req  = !is_d;
    d_req   = is_d;
    d_we    = is_d ? we : $urandom_range(0, 1);
    if_addr = is_d ? $urandom : addr;
    d_addr  = is_d ? addr : $urandom;
    d_wdata = wdata;
    cyc = 0; got = 1'b0;
    strobe_obs = 1'b0; addr_obs = '0; line_obs = '0;
    err_obs = 1'b0; dat_obs = '0; other_obs = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (read && write) both_cnt++;
      if (cyc == 1) begin
        strobe_obs = exp_rd ? read : write;
        addr_obs   = exp_rd ? r_addr : w_addr;
        line_obs   = w_line;
      end
      got = is_d ? d_ack : if_ack;
      if (got) begin
        err_obs   = is_d ? d_err : if_err;
        dat_obs   = is_d ? d_rdata : if_data;
        other_obs = is_d ? (if_ack | if_err) : (d_ack | d_err);
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    checkOutput({tag, "_ack"}, 32'(got), 32'd1);
    checkOutput({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    checkOutput({tag, "_strobe"}, 32'(strobe_obs), 32'd1);
    checkOutput({tag, "_addr"}, addr_obs, addr);
    if (!exp_rd) checkOutput({tag, "_wline"}, line_obs, wdata);
    checkOutput({tag, "_err"}, 32'(err_obs), 32'(exp_err));
    checkOutput({tag, "_data"}, dat_obs, exp_data);
    checkOutput({tag, "_other"}, 32'(other_obs), 32'd0);
  endtask

  initial begin
    int          acks, cyc;
    bit          exp_who;
    logic [31:0] a_if, a_d;

    rst_n = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_strobes", {30'd0, read, write}, 32'd0);
    checkOutput("rst_acks", {28'd0, if_ack, if_err, d_ack, d_err}, 32'd0);
    checkOutput("rst_if_data", if_data, 32'd0);
    checkOutput("rst_d_rdata", d_rdata, 32'd0);
    checkOutput("rst_addrs", r_addr | w_addr | w_line, 32'd0);
    rst_n = 1'b1;

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, "fetch10");
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h12345678, "dwr20");
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, "drd20");
    applyStimulus(1'b1, 1'b0, 32'h40000, 32'h0, "dexc");
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, "fetch_after_exc");

    $display("[TB] contention");
    a_if = 32'h30; a_d = 32'h31;
    @(negedge clk);
    if_req = 1'b1; if_addr = a_if;
    d_req = 1'b1; d_addr = a_d; d_we = 1'b0;
    acks = 0; cyc = 0;
    while (acks < 5 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (read && write) both_cnt++;
      if (if_ack || d_ack) begin
        exp_who = (acks == 4) ? 1'b0 : (RR ? !last_d : 1'b1);
        checkOutput($sformatf("cont%0d_who", acks), 32'(d_ack), 32'(exp_who));
        checkOutput($sformatf("cont%0d_single", acks), 32'(if_ack & d_ack), 32'd0);
        checkOutput($sformatf("cont%0d_data", acks), d_ack ? d_rdata : if_data,
                    ref_mem[exp_who ? a_d[9:0] : a_if[9:0]]);
        last_d = exp_who;
        acks++;
        if (acks == 4) d_req = 1'b0;
        if (acks == 5) if_req = 1'b0;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    checkOutput("cont_acks", 32'(acks), 32'd5);

    $display("[TB] watchdog");
    hang = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h5, 32'h0, "to_fetch");
    applyStimulus(1'b1, 1'b1, 32'h6, 32'hCAFEF00D, "to_dwr");
    hang = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h6, 32'h0, "after_to_rd");

    $display("[TB] reset mid-access");
    hang = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h7;
    repeat (3) @(negedge clk);
    checkOutput("mid_read_hi", 32'(read), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_read", 32'(read), 32'd0);
    checkOutput("mid_rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    if_req = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_d = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, "post_rst_fetch");

    $display("[TB] random accesses");
    for (int n = 0; n < 40; n++) begin
      bit          is_d, we;
      logic [31:0] addr;
      is_d = $urandom_range(0, 1);
      we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      addr = ($urandom_range(0, 9) == 0) ? 32'h40000 + $urandom_range(0, 255)
                                         : 32'($urandom_range(0, 63));
      applyStimulus(is_d, we, addr, $urandom, $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    checkOutput("never_rd_wr", 32'(both_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
